// File: rtl/fnd_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// fnd_scan_sequencer_if
// APB bus bundle for the FND scan sequencer register block.
//   PADDR   [3:0]  register select (PADDR[3:2] = word index)
//   PSEL, PENABLE, PWRITE  APB control
//   PWDATA  [31:0] write data
//   PRDATA  [31:0] read data (slave driven)
//   PREADY         transfer complete (slave driven)
// Modports: master (bus initiator), slave (register block).
// -----------------------------------------------------------------------------
interface fnd_scan_sequencer_if;
    logic [3:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/fnd_scan_sequencer.sv
// -----------------------------------------------------------------------------
// fnd_scan_sequencer
// APB-programmable scan scheduler for the 4-digit FND display. Time-multiplexes
// the shared segment bus across four digits with a programmable dwell (PRE),
// a fixed dead-time gap between digits, per-digit enable and frame-based blink.
//
// Ports:
//   PCLK        system / APB clock
//   PRESET      asynchronous active-high reset
//   apb         APB slave (SCR 0x0, SPR 0x4, SBR 0x8, SSR 0xC read-only)
//   seg_sel     digit currently owning the segment bus (0..3)
//   scan_comm   active-low digit commons, at most one bit low
//   frame_tick  one-cycle pulse on the first DRIVE cycle of each new frame
// -----------------------------------------------------------------------------
module fnd_scan_sequencer #(
    parameter int          GAP_CYCLES = 16,
    parameter logic [15:0] PRE_RESET  = 16'd49999
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    fnd_scan_sequencer_if.slave   apb,
    output logic [1:0]            seg_sel,
    output logic [3:0]            scan_comm,
    output logic                  frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Programmable registers
    logic        en;
    logic        blink_en;
    logic [3:0]  dmask;
    logic [15:0] pre;
    logic [7:0]  blink_half;
    logic        pready_q;
    logic [31:0] prdata_c;

    // Scan state
    state_t      state, state_n;
    logic [1:0]  seg_sel_n;
    logic [15:0] dwell_cnt, dwell_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [7:0]  frame_cnt, frame_n;
    logic [7:0]  blink_cnt, blink_cnt_n;
    logic        blink_vis, blink_vis_n;
    logic        tick_n;
    logic [3:0]  comm_n;
    logic        advance;
    logic        blink_on;
    logic [7:0]  blink_inc;

    logic wr_en;
    logic rd_en;

    assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en = apb.PSEL & apb.PENABLE & ~apb.PWRITE;

    // Address/data bits with no register behind them.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:16]};

    // ---------------- APB register block ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en         <= 1'b0;
            blink_en   <= 1'b0;
            dmask      <= 4'hF;
            pre        <= PRE_RESET;
            blink_half <= 8'd250;
            pready_q   <= 1'b0;
        end else begin
            pready_q <= apb.PSEL & apb.PENABLE;
            if (wr_en) begin
                case (apb.PADDR[3:2])
                    2'd0: begin
                        en       <= apb.PWDATA[0];
                        blink_en <= apb.PWDATA[1];
                        dmask    <= apb.PWDATA[7:4];
                    end
                    2'd1:    pre        <= apb.PWDATA[15:0];
                    2'd2:    blink_half <= apb.PWDATA[7:0];
                    default: ;  // SSR is read-only
                endcase
            end
        end
    end

    assign apb.PREADY = pready_q;

    always_comb begin
        prdata_c = 32'd0;
        if (rd_en) begin
            case (apb.PADDR[3:2])
                2'd0:    prdata_c = {24'd0, dmask, 2'b00, blink_en, en};
                2'd1:    prdata_c = {16'd0, pre};
                2'd2:    prdata_c = {24'd0, blink_half};
                default: prdata_c = {16'd0, frame_cnt, 3'b000, blink_vis, 2'(state), seg_sel};
            endcase
        end
    end

    assign apb.PRDATA = prdata_c;

    // ---------------- Scan FSM: next state ----------------
    always_comb begin
        state_n     = state;
        seg_sel_n   = seg_sel;
        dwell_n     = dwell_cnt;
        gap_n       = gap_cnt;
        frame_n     = frame_cnt;
        blink_cnt_n = blink_cnt;
        blink_vis_n = blink_vis;
        tick_n      = 1'b0;
        advance     = 1'b0;
        comm_n      = 4'hF;
        blink_on    = blink_en && (blink_half != 8'd0);
        blink_inc   = blink_cnt + 8'd1;

        if (!en) begin
            state_n     = ST_IDLE;
            seg_sel_n   = 2'd0;
            dwell_n     = 16'd0;
            gap_n       = '0;
            frame_n     = 8'd0;
            blink_cnt_n = 8'd0;
            blink_vis_n = 1'b1;
        end else begin
            case (state)
                ST_IDLE: state_n = ST_DRIVE;
                ST_DRIVE: begin
                    // >= rather than == so a PRE shrunk below the running
                    // count ends the dwell on the next edge.
                    if (dwell_cnt >= pre) begin
                        if (GAP_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_n = ST_GAP;
                            gap_n   = '0;
                        end
                    end else begin
                        dwell_n = dwell_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_n = gap_cnt + GW'(1);
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (advance) begin
            state_n   = ST_DRIVE;
            seg_sel_n = seg_sel + 2'd1;
            dwell_n   = 16'd0;
            gap_n     = '0;
            // Wrapping 3->0 closes a frame.
            if (seg_sel == 2'd3) begin
                tick_n  = 1'b1;
                frame_n = frame_cnt + 8'd1;
                if (blink_on) begin
                    if (blink_inc >= blink_half) begin
                        blink_vis_n = ~blink_vis;
                        blink_cnt_n = 8'd0;
                    end else begin
                        blink_cnt_n = blink_inc;
                    end
                end
            end
        end

        if (!blink_on) begin
            blink_vis_n = 1'b1;
            blink_cnt_n = 8'd0;
        end

        // Commons are registered from next-state values so they line up with
        // the state register; masked digits still occupy their slot.
        if ((state_n == ST_DRIVE) && dmask[seg_sel_n] && blink_vis_n) begin
            comm_n[seg_sel_n] = 1'b0;
        end
    end

    // ---------------- Scan FSM: state register ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            seg_sel    <= 2'd0;
            dwell_cnt  <= 16'd0;
            gap_cnt    <= '0;
            frame_cnt  <= 8'd0;
            blink_cnt  <= 8'd0;
            blink_vis  <= 1'b1;
            frame_tick <= 1'b0;
            scan_comm  <= 4'hF;
        end else begin
            state      <= state_n;
            seg_sel    <= seg_sel_n;
            dwell_cnt  <= dwell_n;
            gap_cnt    <= gap_n;
            frame_cnt  <= frame_n;
            blink_cnt  <= blink_cnt_n;
            blink_vis  <= blink_vis_n;
            frame_tick <= tick_n;
            scan_comm  <= comm_n;
        end
    end

endmodule

// File: tb/tb_fnd_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_sequencer
// Directed bench for fnd_scan_sequencer with GAP_CYCLES=2. Inputs are driven
// and outputs sampled on the falling edge of PCLK.
// -----------------------------------------------------------------------------
module tb_fnd_scan_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic [1:0] seg_sel;
    logic [3:0] scan_comm;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    fnd_scan_sequencer_if bus ();

    fnd_scan_sequencer #(.GAP_CYCLES(2)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .apb       (bus),
        .seg_sel   (seg_sel),
        .scan_comm (scan_comm),
        .frame_tick(frame_tick)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected commons for sample i after enable with PRE=3, GAP=2 (24-cycle frame).
    function automatic logic [3:0] exp_comm(input int i, input logic [3:0] mask, input bit vis);
        int slot;
        int d;
        logic [3:0] one_hot;
        slot    = i % 24;
        d       = slot / 6;
        one_hot = 4'b0001 << d;
        if ((slot % 6) < 4 && mask[d] && vis) return ~one_hot;
        return 4'hF;
    endfunction

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = addr;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        data = bus.PRDATA;
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // Returns on the falling edge of the first DRIVE cycle (sample index 0).
    task automatic start_scan(input logic [31:0] scr);
        apb_write(4'h0, 32'h0);
        apb_write(4'h0, scr);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        @(negedge PCLK);
        checks++; if (seg_sel !== 2'd0) begin errors++; $display("FAIL rst_seg_sel got %0d want 0", seg_sel); end
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL rst_scan_comm got %b want 1111", scan_comm); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_frame_tick got %b want 0", frame_tick); end
        checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready got %b want 0", bus.PREADY); end
        checks++; if (bus.PRDATA !== 32'd0) begin errors++; $display("FAIL rst_prdata got %h want 0", bus.PRDATA); end
        PRESET = 1'b0;
        @(negedge PCLK);
        // Hand-run read of SPR to watch PREADY timing.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h4;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL pready_access_start got %b want 0", bus.PREADY); end
        checks++; if (bus.PRDATA !== 32'd49999) begin errors++; $display("FAIL spr_reset got %0d want 49999", bus.PRDATA); end
        @(negedge PCLK);
        checks++; if (bus.PREADY !== 1'b1) begin errors++; $display("FAIL pready_wait got %b want 1", bus.PREADY); end
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL pready_idle got %b want 0", bus.PREADY); end
        apb_read(4'h0, rd);
        checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL scr_reset got %h want 000000f0", rd); end
        apb_read(4'h8, rd);
        checks++; if (rd !== 32'd250) begin errors++; $display("FAIL sbr_reset got %0d want 250", rd); end
        apb_read(4'hC, rd);
        checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL ssr_reset got %h want 00000010", rd); end
    endtask

    task automatic test_scan();
        logic [31:0] rd;
        apb_write(4'h4, 32'd3);
        start_scan(32'h0000_00F1);
        for (int i = 0; i <= 48; i++) begin
            checks++; if (scan_comm !== exp_comm(i, 4'hF, 1'b1)) begin errors++; $display("FAIL scan_comm[%0d] got %b want %b", i, scan_comm, exp_comm(i, 4'hF, 1'b1)); end
            checks++; if (seg_sel !== 2'((i % 24) / 6)) begin errors++; $display("FAIL scan_seg_sel[%0d] got %0d want %0d", i, seg_sel, (i % 24) / 6); end
            checks++; if (frame_tick !== ((i % 24 == 0) && (i > 0))) begin errors++; $display("FAIL scan_tick[%0d] got %b", i, frame_tick); end
            @(negedge PCLK);
        end
        apb_read(4'hC, rd);   // sampled at index 51
        checks++; if (rd !== 32'h0000_0214) begin errors++; $display("FAIL ssr_frame2 got %h want 00000214", rd); end
        repeat (20) @(negedge PCLK);
        apb_read(4'hC, rd);   // sampled at index 74
        checks++; if (rd !== 32'h0000_0314) begin errors++; $display("FAIL ssr_frame3 got %h want 00000314", rd); end
    endtask

    task automatic test_dmask();
        start_scan(32'h0000_0051);
        for (int i = 0; i <= 48; i++) begin
            checks++; if (scan_comm !== exp_comm(i, 4'b0101, 1'b1)) begin errors++; $display("FAIL dmask_comm[%0d] got %b want %b", i, scan_comm, exp_comm(i, 4'b0101, 1'b1)); end
            checks++; if (frame_tick !== ((i % 24 == 0) && (i > 0))) begin errors++; $display("FAIL dmask_tick[%0d] got %b", i, frame_tick); end
            @(negedge PCLK);
        end
    endtask

    task automatic test_blink();
        logic [31:0] rd;
        apb_write(4'h0, 32'h0);
        apb_write(4'h8, 32'd2);
        apb_write(4'h0, 32'h0000_00F3);
        for (int i = 0; i < 72; i++) begin
            checks++; if (scan_comm !== exp_comm(i, 4'hF, ((i / 24) / 2) % 2 == 0)) begin errors++; $display("FAIL blink_comm[%0d] got %b want %b", i, scan_comm, exp_comm(i, 4'hF, ((i / 24) / 2) % 2 == 0)); end
            @(negedge PCLK);
        end
        apb_read(4'hC, rd);   // sampled at index 74, hidden frame
        checks++; if (rd !== 32'h0000_0304) begin errors++; $display("FAIL ssr_blink_hidden got %h want 00000304", rd); end
        apb_write(4'h8, 32'd0);   // returns at index 78
        for (int i = 78; i < 102; i++) begin
            checks++; if (scan_comm !== exp_comm(i, 4'hF, 1'b1)) begin errors++; $display("FAIL blink_off_comm[%0d] got %b want %b", i, scan_comm, exp_comm(i, 4'hF, 1'b1)); end
            @(negedge PCLK);
        end
        apb_read(4'hC, rd);   // sampled at index 104
        checks++; if (rd !== 32'h0000_0415) begin errors++; $display("FAIL ssr_blink_off got %h want 00000415", rd); end
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        start_scan(32'h0000_00F1);
        repeat (11) @(negedge PCLK);
        apb_write(4'h0, 32'h0000_00F0);   // EN drops during digit 2 DRIVE
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL dis_comm got %b want 1111", scan_comm); end
        checks++; if (seg_sel !== 2'd0) begin errors++; $display("FAIL dis_seg_sel got %0d want 0", seg_sel); end
        apb_read(4'hC, rd);
        checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL dis_ssr got %h want 00000010", rd); end
        apb_write(4'h0, 32'h0000_00F1);
        for (int k = 0; k < 6; k++) begin
            checks++; if (scan_comm !== ((k < 4) ? 4'b1110 : 4'hF)) begin errors++; $display("FAIL reen_comm[%0d] got %b", k, scan_comm); end
            checks++; if (seg_sel !== 2'd0) begin errors++; $display("FAIL reen_seg_sel[%0d] got %0d want 0", k, seg_sel); end
            @(negedge PCLK);
        end
    endtask

    task automatic test_pre_shrink();
        apb_write(4'h0, 32'h0);
        apb_write(4'h4, 32'd1000);
        apb_write(4'h0, 32'h0000_00F1);
        repeat (598) @(negedge PCLK);
        checks++; if (scan_comm !== 4'b1110) begin errors++; $display("FAIL pre_long_drive got %b want 1110", scan_comm); end
        apb_write(4'h4, 32'd100);   // PRE lands with dwell at 600
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL pre_shrink_gap got %b want 1111", scan_comm); end
        @(negedge PCLK);
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL pre_shrink_gap2 got %b want 1111", scan_comm); end
        @(negedge PCLK);
        checks++; if (scan_comm !== 4'b1101) begin errors++; $display("FAIL pre_shrink_next got %b want 1101", scan_comm); end
        checks++; if (seg_sel !== 2'd1) begin errors++; $display("FAIL pre_shrink_sel got %0d want 1", seg_sel); end
    endtask

    task automatic test_ssr_readonly();
        logic [31:0] rd;
        apb_write(4'h0, 32'h0);
        apb_write(4'hC, 32'hFFFF_FFFF);
        apb_read(4'hC, rd);
        checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL ssr_ro got %h want 00000010", rd); end
        apb_read(4'h4, rd);
        checks++; if (rd !== 32'd100) begin errors++; $display("FAIL ssr_ro_spr got %0d want 100", rd); end
        apb_read(4'h0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ssr_ro_scr got %h want 0", rd); end
        apb_write(4'h8, 32'h0000_1234);
        apb_read(4'h8, rd);
        checks++; if (rd !== 32'h0000_0034) begin errors++; $display("FAIL sbr_width got %h want 00000034", rd); end
    endtask

    task automatic test_preset_async();
        logic [31:0] rd;
        apb_write(4'h4, 32'd3);
        start_scan(32'h0000_00F1);
        repeat (10) @(negedge PCLK);   // digit 1 gap
        checks++; if (seg_sel !== 2'd1) begin errors++; $display("FAIL prst_pre_sel got %0d want 1", seg_sel); end
        PRESET = 1'b1;
        #1;
        checks++; if (seg_sel !== 2'd0) begin errors++; $display("FAIL prst_seg_sel got %0d want 0", seg_sel); end
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL prst_comm got %b want 1111", scan_comm); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL prst_tick got %b want 0", frame_tick); end
        checks++; if (bus.PREADY !== 1'b0) begin errors++; $display("FAIL prst_pready got %b want 0", bus.PREADY); end
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        apb_read(4'h4, rd);
        checks++; if (rd !== 32'd49999) begin errors++; $display("FAIL prst_spr got %0d want 49999", rd); end
        apb_read(4'h0, rd);
        checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL prst_scr got %h want 000000f0", rd); end
        checks++; if (scan_comm !== 4'hF) begin errors++; $display("FAIL prst_idle_comm got %b want 1111", scan_comm); end
    endtask

    initial begin
        PRESET      = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 4'h0;
        bus.PWDATA  = 32'h0;
        test_reset();
        test_scan();
        test_dmask();
        test_blink();
        test_disable();
        test_pre_shrink();
        test_ssr_readonly();
        test_preset_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_sequencer.md
# fnd_scan_sequencer

APB-programmable scan scheduler for the 4-digit FND display. It replaces the fixed 1 kHz divider and free-running digit counter with a controller that time-multiplexes the shared segment bus across the four digits. Scan rate, inter-digit blanking, per-digit enable and blinking are all under software control. It drives `seg_sel` into the FND digit/font datapath and produces the active-low digit commons directly.

## Interface
- GAP_CYCLES, 16: PCLK cycles of all-commons-off dead time between digits; 0 means no gap.
- PRE_RESET, 49999: reset value of SPR.PRE.
- PCLK  in  1  APB/system clock.
- PRESET  in  1  reset; asynchronous, active-high.
- PADDR  in  4  register select; PADDR[3:2] is the word index.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- seg_sel  out  2  digit currently owning the segment bus (0..3).
- scan_comm  out  4  active-low digit commons; at most one bit is low.
- frame_tick  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Registers:
  - 0x0 SCR: [0] EN, [1] BLINK_EN, [7:4] DMASK (1 = digit lit). Reset 0x000000F0.
  - 0x4 SPR: [15:0] PRE. Reset PRE_RESET.
  - 0x8 SBR: [7:0] BLINK_HALF, in frames. Reset 250.
  - 0xC SSR: read-only. [1:0] seg_sel, [3:2] state (0 IDLE, 1 DRIVE, 2 GAP), [4] blink_vis, [15:8] frame_cnt. Writes are ignored.
  - Unused bits read 0 and are not stored.
- APB behaviour:
  - A write is captured on every PCLK edge where PSEL & PENABLE & PWRITE.
  - PREADY is registered: PREADY <= PSEL & PENABLE, so there is one wait state.
  - PRDATA is combinational when PSEL & PENABLE & !PWRITE, and 0 otherwise.
- FSM states:
  - IDLE: seg_sel=0, scan_comm=4'hF, dwell/gap/blink/frame counters held at 0, blink_vis=1. Leaves to DRIVE when EN=1.
  - DRIVE: scan_comm[seg_sel]=0 iff DMASK[seg_sel] & blink_vis; otherwise 4'hF. dwell_cnt increments each cycle. When dwell_cnt >= PRE, go to GAP, or advance directly if GAP_CYCLES=0.
  - GAP: scan_comm=4'hF for exactly GAP_CYCLES cycles, then advance.
  - Advance: seg_sel+1, wrapping 3->0, dwell_cnt=0, re-enter DRIVE. Wrapping 3->0 ends a frame.
- Frame end:
  - frame_cnt+1 (8-bit, wraps 255->0).
  - frame_tick=1 for the first DRIVE cycle of digit 0.
  - If BLINK_EN and BLINK_HALF!=0: blink_cnt+1; when blink_cnt reaches BLINK_HALF, toggle blink_vis and clear blink_cnt.
- Blink off: BLINK_EN=0 or BLINK_HALF=0 forces blink_vis=1 and blink_cnt=0.
- Masked digits keep their full dwell and gap slots, so the frame rate never depends on DMASK.
- EN=0 in any state forces IDLE on the next edge. Re-enabling always starts at digit 0 with fresh counters.
- PRE rewritten mid-dwell takes effect immediately through the >= compare, so a shrunken PRE ends the dwell on the next edge.

## Timing
- All outputs except PRDATA are registered.
- Reset values: seg_sel=0, scan_comm=4'hF, frame_tick=0, PREADY=0, PRDATA=0, FSM=IDLE.
- EN written at edge T: SCR updates at T; DRIVE begins and scan_comm goes low at T+1. No frame_tick is issued for this first frame.
- DRIVE lasts PRE+1 cycles and GAP lasts GAP_CYCLES cycles.
- Frame length is 4*(PRE+1+GAP_CYCLES) cycles. With PRE=49999, GAP_CYCLES=16 at 100 MHz this is 2.00064 ms.
- DMASK/BLINK_EN writes apply to scan_comm on the next edge.
- A write and a frame end in the same cycle: the counters use the old register value for that edge.
- PRESET asynchronously forces all reset values mid-scan or mid-transfer.

## Test plan
- Reset: check every output's reset value. APB read 0x4 returns 49999; read 0x0 returns 0xF0; PREADY is high exactly one cycle after the access phase starts.
- Bench GAP_CYCLES=2, PRE=3, EN=1:
  - scan_comm goes 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4, 1111 x2.
  - frame_tick pulses every 24 cycles.
  - SSR[15:8] increments per frame.
- DMASK=4'b0101: digits 1 and 3 stay 4'hF for their full 4-cycle slots; digits 0 and 2 are lit; period is still 24 cycles.
- BLINK_EN=1, BLINK_HALF=2: commons toggle every 2 frames (2 frames visible, 2 frames all-high); SSR[4] tracks blink_vis. Setting BLINK_HALF=0 restores constant visibility.
- Clear EN during digit 2 DRIVE: next edge gives scan_comm=4'hF, seg_sel=0, SSR state=0. Re-enable restarts with digit 0 lit for a full PRE+1 cycles.
- PRE=1000 with dwell_cnt=600, then write PRE=100: DRIVE ends on the next edge. A write to 0xC leaves SSR unchanged. PRESET pulsed mid-GAP returns all outputs to reset values immediately.
